// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the EX->MEM result stage.
//   buf_state_e : occupancy/trap state of the result stage's 2-entry buffer
//   entry_t     : layout of one buffered beat at the default datapath widths
//   entry_w()   : packed width of an entry for arbitrary datapath widths
package pipe_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int REG_AW_DEF    = 5;
    localparam int CAUSE_OVF_DEF = 12;
    localparam int CAUSE_W       = 5;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_ONE       = 2'd1,
        ST_TWO       = 2'd2,
        ST_TRAP_WAIT = 2'd3
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic                  reg_write;
        logic [REG_AW_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] pc;
        logic                  trap;
    } entry_t;

    // result + pc + rd + reg_write + trap
    function automatic int entry_w(input int dw, input int aw);
        return 2 * dw + aw + 2;
    endfunction

endpackage

// File: rtl/ex_result_stage_skid_buf2.sv
// skid_buf2: two-entry in-order buffer of opaque W-bit entries.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write din_i behind the current contents (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : discard all entries; wins over push/pop
//   din_i      : entry to push
//   head_o     : oldest entry; keeps its last value once the buffer empties
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d, cnt_pop;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_pop = cnt_q;
        if (pop_i && (cnt_q != 2'd0)) begin
            cnt_pop = cnt_q - 2'd1;
            // Only shift when a second entry exists, so a drained head holds.
            if (cnt_q == 2'd2) begin
                ent0_d = ent1_q;
            end
        end
        cnt_d = cnt_pop;
        if (push_i && (cnt_pop != 2'd2)) begin
            if (cnt_pop == 2'd0) begin
                ent0_d = din_i;
            end else begin
                ent1_d = din_i;
            end
            cnt_d = cnt_pop + 2'd1;
        end
        if (flush_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o = ent0_q;

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: EX->MEM boundary register behind the ALU. Selects the
// result (ALU word or compare bit), converts trapping overflow into a precise
// exception at the head of a 2-entry skid buffer, and handshakes both sides.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : ALU-side handshake (in_ready is registered)
//   aluout, compout, overflow, slt_sel, trap_en, reg_write, rd_addr, pc : beat
//   flush              : synchronous kill of all held beats
//   out_valid/out_ready, out_result, out_reg_write, out_rd : MEM-side beat
//   exc_valid, exc_pc, exc_cause, exc_ack : overflow trap at head
// Build option EX_STAGE_STATS_EN adds stat_beats / stat_traps (saturating
// counts of accepted beats and acknowledged traps; cleared only by reset).
//
// state        | meaning
// ST_EMPTY     | no beat held
// ST_ONE       | one non-trap beat held, presented to MEM
// ST_TWO       | two beats held, head is non-trap (tail may be the trap)
// ST_TRAP_WAIT | trap beat at head, waiting for exc_ack
module ex_result_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int CAUSE_OVF = CAUSE_OVF_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  aluout,
    input  logic               compout,
    input  logic               overflow,
    input  logic               slt_sel,
    input  logic               trap_en,
    input  logic               reg_write,
    input  logic [REG_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic               out_reg_write,
    output logic [REG_AW-1:0]  out_rd,
    output logic               exc_valid,
    output logic [DATA_W-1:0]  exc_pc,
    output logic [CAUSE_W-1:0] exc_cause,
`ifdef EX_STAGE_STATS_EN
    output logic [15:0]        stat_beats,
    output logic [15:0]        stat_traps,
`endif
    input  logic               exc_ack
);

    // Same field order as pipe_pkg::entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] pc;
        logic              trap;
    } stage_entry_t;

    localparam int ENTRY_W = entry_w(DATA_W, REG_AW);

    buf_state_e   state_q, state_d;
    logic         trap_latched_q, trap_latched_d;
    logic         ready_q;
    logic         push, pop, drop, in_trap;
    stage_entry_t in_entry, head;
    logic [ENTRY_W-1:0] head_bits;

    assign in_trap = overflow && trap_en && !slt_sel;
    assign push    = in_valid && ready_q && !flush;

    always_comb begin
        in_entry.result    = slt_sel ? {{(DATA_W-1){1'b0}}, compout} : aluout;
        in_entry.reg_write = reg_write;
        in_entry.rd        = rd_addr;
        in_entry.pc        = pc;
        in_entry.trap      = in_trap;
    end

    assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign exc_valid = (state_q == ST_TRAP_WAIT);
    // An acknowledged trap leaves the buffer without ever reaching MEM.
    assign drop      = exc_valid && exc_ack;
    assign pop       = (out_valid && out_ready) || drop;

    skid_buf2 #(.W(ENTRY_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (in_entry),
        .head_o  (head_bits)
    );

    assign head = stage_entry_t'(head_bits);

    always_comb begin
        state_d        = state_q;
        trap_latched_d = trap_latched_q;
        if (flush) begin
            state_d        = ST_EMPTY;
            trap_latched_d = 1'b0;
        end else begin
            if (push && in_trap) trap_latched_d = 1'b1;
            if (drop)            trap_latched_d = 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (push) state_d = in_trap ? ST_TRAP_WAIT : ST_ONE;
                end
                ST_ONE: begin
                    if (push && pop)  state_d = in_trap ? ST_TRAP_WAIT : ST_ONE;
                    else if (push)    state_d = ST_TWO;
                    else if (pop)     state_d = ST_EMPTY;
                end
                ST_TWO: begin
                    // A trap can only ever be the youngest beat, so in TWO a
                    // latched trap means the tail is the trap.
                    if (pop) state_d = trap_latched_q ? ST_TRAP_WAIT : ST_ONE;
                end
                ST_TRAP_WAIT: begin
                    if (drop) state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            trap_latched_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            trap_latched_q <= trap_latched_d;
            ready_q        <= (state_d != ST_TWO) && !trap_latched_d;
        end
    end

    assign in_ready      = ready_q;
    assign out_result    = head.result;
    assign out_reg_write = head.reg_write;
    assign out_rd        = head.rd;
    assign exc_pc        = head.pc;
    assign exc_cause     = head.trap ? CAUSE_W'(CAUSE_OVF) : '0;

`ifdef EX_STAGE_STATS_EN
    logic [15:0] beats_q, traps_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q <= '0;
            traps_q <= '0;
        end else begin
            if (push && (beats_q != 16'hFFFF))          beats_q <= beats_q + 16'd1;
            if (drop && !flush && (traps_q != 16'hFFFF)) traps_q <= traps_q + 16'd1;
        end
    end

    assign stat_beats = beats_q;
    assign stat_traps = traps_q;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] aluout;
    logic        compout, overflow, slt_sel, trap_en, reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_reg_write;
    logic [4:0]  out_rd;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [4:0]  exc_cause;
    logic        exc_ack;
`ifdef EX_STAGE_STATS_EN
    logic [15:0] stat_beats, stat_traps;
`endif

    ex_result_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .aluout        (aluout),
        .compout       (compout),
        .overflow      (overflow),
        .slt_sel       (slt_sel),
        .trap_en       (trap_en),
        .reg_write     (reg_write),
        .rd_addr       (rd_addr),
        .pc            (pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_reg_write (out_reg_write),
        .out_rd        (out_rd),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .exc_cause     (exc_cause),
`ifdef EX_STAGE_STATS_EN
        .stat_beats    (stat_beats),
        .stat_traps    (stat_traps),
`endif
        .exc_ack       (exc_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t        out_q[$];
    logic [31:0] exc_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every beat MEM takes and every trap acknowledged.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got result 0x%08h rd %0d, expected none", out_result, out_rd);
                end else begin
                    exp_t e;
                    e = out_q.pop_front();
                    check("beat_result", out_result, e.res);
                    check("beat_rd", 32'(out_rd), 32'(e.rd));
                    check("beat_reg_write", 32'(out_reg_write), 32'(e.rw));
                end
            end
            if (exc_valid && exc_ack) begin
                if (exc_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_trap: got exc_pc 0x%08h, expected none", exc_pc);
                end else begin
                    logic [31:0] epc;
                    epc = exc_q.pop_front();
                    check("trap_pc", exc_pc, epc);
                    check("trap_cause", 32'(exc_cause), 32'd12);
                end
            end
        end
    end

    // Drive one beat and hold it until accepted; expected outcome is given by hand.
    task automatic send(input logic [31:0] a, input logic c, input logic ovf, input logic slt,
                        input logic te, input logic rw, input logic [4:0] rd, input logic [31:0] p,
                        input logic [31:0] exp_res, input logic exp_trap);
        bit   ok;
        exp_t e;
        aluout = a; compout = c; overflow = ovf; slt_sel = slt; trap_en = te;
        reg_write = rw; rd_addr = rd; pc = p; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                if (exp_trap) exc_q.push_back(p);
                else begin
                    e.res = exp_res; e.rd = rd; e.rw = rw;
                    out_q.push_back(e);
                end
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat pc 0x%08h not accepted, expected acceptance", p);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (out_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check(name, 32'(out_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; aluout = '0; compout = 1'b0; overflow = 1'b0;
        slt_sel = 1'b0; trap_en = 1'b0; reg_write = 1'b0; rd_addr = '0; pc = '0;
        flush = 1'b0; out_ready = 1'b0; exc_ack = 1'b0;

        // Reset values
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_exc_valid", 32'(exc_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_exc_cause", 32'(exc_cause), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Streaming with MEM always ready
        out_ready = 1'b1;
        send(32'h5, 0, 0, 0, 0, 1, 5'd3, 32'h400000, 32'h5, 0);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_result", out_result, 32'h5);
        check("lat_out_rd", 32'(out_rd), 32'd3);
        send(32'h10, 0, 0, 0, 0, 1, 5'd4, 32'h400004, 32'h10, 0);
        check("stream_ready", 32'(in_ready), 32'd1);
        send(32'hFFFF_FFFF, 1, 0, 1, 0, 1, 5'd6, 32'h400008, 32'h1, 0);
        send(32'h8000_0001, 0, 1, 1, 1, 1, 5'd7, 32'h40000c, 32'h0, 0);
        send(32'h8000_0000, 0, 1, 0, 0, 1, 5'd8, 32'h400010, 32'h8000_0000, 0);
        send(32'h1234_5678, 0, 0, 0, 0, 0, 5'd9, 32'h400014, 32'h1234_5678, 0);
        drain("stream_drain");

        // Older beat drains, then the trap waits for exc_ack
        send(32'h7, 0, 0, 0, 0, 1, 5'd5, 32'h40000c, 32'h7, 0);
        send(32'h7FFF_FFFF, 0, 1, 0, 1, 1, 5'd10, 32'h400010, 32'h0, 1);
        for (int i = 0; i < 10 && !exc_valid; i++) begin
            @(posedge clk); #1;
        end
        check("trap_exc_valid", 32'(exc_valid), 32'd1);
        check("trap_exc_pc", exc_pc, 32'h400010);
        check("trap_exc_cause", 32'(exc_cause), 32'd12);
        check("trap_out_valid", 32'(out_valid), 32'd0);
        check("trap_in_ready", 32'(in_ready), 32'd0);
        check("trap_older_drained", 32'(out_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("trap_hold", 32'(exc_valid), 32'd1);
        end
        exc_ack = 1'b1;
        @(posedge clk); #1;
        exc_ack = 1'b0;
        check("ack_exc_valid", 32'(exc_valid), 32'd0);
        check("ack_out_valid", 32'(out_valid), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd1);
        check("ack_exc_q", 32'(exc_q.size()), 32'd0);

        // exc_ack without a trap at the head is ignored
        out_ready = 1'b0;
        exc_ack   = 1'b1;
        send(32'h55, 0, 0, 0, 0, 1, 5'd11, 32'h400018, 32'h55, 0);
        repeat (2) @(posedge clk);
        #1;
        check("stray_ack_out_valid", 32'(out_valid), 32'd1);
        check("stray_ack_result", out_result, 32'h55);
        exc_ack   = 1'b0;
        out_ready = 1'b1;
        drain("stray_ack_drain");

        // Back-pressure: two beats fill the buffer, the third waits
        out_ready = 1'b0;
        fork
            begin
                send(32'hA1, 0, 0, 0, 0, 1, 5'd12, 32'h400020, 32'hA1, 0);
                send(32'hA2, 0, 0, 0, 0, 1, 5'd13, 32'h400024, 32'hA2, 0);
                send(32'hA3, 0, 0, 0, 0, 1, 5'd14, 32'h400028, 32'hA3, 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_head", out_result, 32'hA1);
                check("bp_held", 32'(out_q.size()), 32'd2);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Flush with a normal beat plus a latched trap buffered
        out_ready = 1'b0;
        send(32'hC0, 0, 0, 0, 0, 1, 5'd15, 32'h400030, 32'hC0, 0);
        send(32'h7FFF_FFFF, 0, 1, 0, 1, 1, 5'd16, 32'h400034, 32'h0, 1);
        check("fl_pre_out_valid", 32'(out_valid), 32'd1);
        check("fl_pre_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_q.delete();
        exc_q.delete();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_exc_valid", 32'(exc_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);

        // Flush in ONE with a beat offered the same cycle: the beat is lost
        send(32'hE0, 0, 0, 0, 0, 1, 5'd17, 32'h400038, 32'hE0, 0);
        aluout = 32'hBAD; rd_addr = 5'd18; pc = 32'h40003c;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_q.delete();
        check("fl2_out_valid", 32'(out_valid), 32'd0);
        check("fl2_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("fl2_no_ghost", 32'(out_valid), 32'd0);
        send(32'hF0, 0, 0, 0, 0, 1, 5'd19, 32'h400040, 32'hF0, 0);
        drain("post_flush_drain");

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h99, 0, 0, 0, 0, 1, 5'd20, 32'h400044, 32'h99, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_rd", 32'(out_rd), 32'd0);
        check("arst_out_reg_write", 32'(out_reg_write), 32'd0);
        check("arst_exc_valid", 32'(exc_valid), 32'd0);
        check("arst_exc_pc", exc_pc, 32'd0);
        out_q.delete();
        exc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_release_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
